// File: rtl/serial_spi_bridge_pkg.sv
// Shared opcodes, reply codes and FSM encoding for the host-stream to SPI-flash bridge.
package serial_spi_bridge_pkg;

    localparam logic [7:0] OP_XFER  = 8'h01;
    localparam logic [7:0] OP_PING  = 8'h02;
    localparam logic [7:0] RPL_PING = 8'hA5;
    localparam logic [7:0] RPL_ERR  = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_CS_SETUP,
        S_WAIT_DATA,
        S_SHIFT,
        S_RESP,
        S_CS_HOLD,
        S_REPLY
    } state_t;

    // States that keep the flash selected unconditionally; CS_HOLD is handled by its timer.
    function automatic logic cs_active(input state_t s);
        return (s == S_CS_SETUP) || (s == S_WAIT_DATA) || (s == S_SHIFT) || (s == S_RESP);
    endfunction

endpackage

// File: rtl/serial_spi_bridge_fifo.sv
// Synchronous byte FIFO, show-ahead dout valid while not empty; zero-latency read, one-cycle write.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_spi_bridge.sv
// Host byte stream to SPI mode-0 flash bridge: PING/ERR replies and length-prefixed full-duplex XFER.
// Replies wait on uart_tx_ready with SPI paused; rx bytes cannot be back-pressured and overflow is sticky.
module serial_spi_bridge
    import serial_spi_bridge_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_strobe,
    input  logic       uart_tx_ready,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_strobe,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy,
    output logic       overflow
);

    localparam logic [8:0] DIV_HALF  = 9'(CLK_DIV);
    localparam logic [8:0] DIV_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

    state_t      state;
    state_t      state_next;

    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    logic [7:0]  len_hi;
    logic [15:0] count;
    logic [8:0]  div_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [7:0]  tx_data;
    logic        sck;
    logic        tx_strobe;
    logic        div_last;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (uart_rx_strobe),
        .din   (uart_rx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign div_last = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx_strobe  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = (fifo_dout == OP_XFER) ? S_LEN_HI : S_REPLY;
                end
            end
            S_LEN_HI: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ({len_hi, fifo_dout} == 16'd0) ? S_IDLE : S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (div_last) state_next = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_last && sck && (bit_cnt == 3'd7)) state_next = S_RESP;
            end
            S_RESP: begin
                if (uart_tx_ready) begin
                    tx_strobe  = 1'b1;
                    state_next = (count == 16'd1) ? S_CS_HOLD : S_WAIT_DATA;
                end
            end
            S_CS_HOLD: begin
                if (div_cnt == HOLD_LAST) state_next = S_IDLE;
            end
            S_REPLY: begin
                if (uart_tx_ready) begin
                    tx_strobe  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // div_cnt restarts on every state change so each timed state begins from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi   <= '0;
            count    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tx_data  <= '0;
            sck      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (uart_rx_strobe && fifo_full && !fifo_pop) overflow <= 1'b1;

            if ((state_next != state) || (state == S_SHIFT && div_last)) div_cnt <= '0;
            else                                                         div_cnt <= div_cnt + 9'd1;

            case (state)
                S_IDLE: begin
                    if (fifo_pop && fifo_dout != OP_XFER)
                        tx_data <= (fifo_dout == OP_PING) ? RPL_PING : RPL_ERR;
                end
                S_LEN_HI: begin
                    if (fifo_pop) len_hi <= fifo_dout;
                end
                S_LEN_LO: begin
                    if (fifo_pop) count <= {len_hi, fifo_dout};
                end
                S_WAIT_DATA: begin
                    if (fifo_pop) begin
                        tx_sh   <= fifo_dout;
                        bit_cnt <= '0;
                        sck     <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (div_last) begin
                        sck <= !sck;
                        if (!sck) begin
                            rx_sh <= {rx_sh[6:0], spi_miso};
                        end else begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) tx_data <= rx_sh;
                        end
                    end
                end
                S_RESP: begin
                    if (tx_strobe) count <= count - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign spi_sck        = sck;
    assign spi_mosi       = tx_sh[7];
    assign spi_cs_n       = !(cs_active(state) || (state == S_CS_HOLD && div_cnt < DIV_HALF));
    assign uart_tx_data   = tx_data;
    assign uart_tx_strobe = tx_strobe;
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_serial_spi_bridge.sv
// Directed scenarios with a tx scoreboard and a mode-0 SPI flash model.
module tb_serial_spi_bridge;

    localparam int CLK_DIV = 2;
    localparam int DEPTH   = 16;
    localparam int TCLK    = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_strobe = 1'b0;
    logic       uart_tx_ready = 1'b1;
    logic [7:0] uart_tx_data;
    logic       uart_tx_strobe;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso = 1'b0;
    logic       busy;
    logic       overflow;

    serial_spi_bridge #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_strobe (uart_rx_strobe),
        .uart_tx_ready  (uart_tx_ready),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_strobe (uart_tx_strobe),
        .spi_cs_n       (spi_cs_n),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #(TCLK / 2) clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] mosi_q[$];

    int   tx_cnt = 0;
    int   sck_rise = 0;
    int   cs_fall = 0;
    int   cs_rise = 0;
    int   bitn = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] miso_sh = 8'h00;
    time  last_rise = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // tx scoreboard
    always @(negedge clk) begin
        if (!reset && uart_tx_strobe === 1'b1) begin
            tx_cnt++;
            check("strobe_ready", {31'd0, uart_tx_ready}, 1);
            if (exp_q.size() == 0) check("tx_extra", 0, 1);
            else                   check("tx_data", {24'd0, uart_tx_data}, {24'd0, exp_q.pop_front()});
        end
    end

    // SPI flash model: presents MSB at CS fall, shifts on SCK fall, samples MOSI on SCK rise
    always @(negedge spi_cs_n) begin
        cs_fall++;
        bitn = 0;
        miso_sh = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
        spi_miso = miso_sh[7];
    end

    always @(posedge spi_cs_n) begin
        cs_rise++;
        bitn = 0;
    end

    always @(posedge spi_sck) begin
        sck_rise++;
        check("cs_low_at_sck", {31'd0, spi_cs_n}, 0);
        if (bitn > 0) check("sck_period", 32'($time - last_rise), 2 * CLK_DIV * TCLK);
        last_rise = $time;
        mosi_sh = {mosi_sh[6:0], spi_mosi};
        miso_sh = {miso_sh[6:0], 1'b0};
        bitn++;
        if (bitn == 8) begin
            bitn = 0;
            if (mosi_q.size() == 0) check("mosi_extra", 0, 1);
            else                    check("mosi_byte", {24'd0, mosi_sh}, {24'd0, mosi_q.pop_front()});
            if (miso_q.size() != 0) miso_sh = miso_q.pop_front();
        end
    end

    always @(negedge spi_sck) spi_miso = miso_sh[7];

    task automatic send(input logic [7:0] b);
        uart_rx_data   = b;
        uart_rx_strobe = 1'b1;
        @(posedge clk);
        #1;
        uart_rx_strobe = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int run = 0;
        repeat (2) @(posedge clk);
        for (int n = 0; n < 3000 && run < 4; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) run++;
            else                            run = 0;
        end
        check(tag, (run >= 4) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rises(input string tag, input int target);
        for (int n = 0; n < 2000 && sck_rise < target; n++) @(negedge clk);
        check(tag, (sck_rise >= target) ? 1 : 0, 1);
    endtask

    int b_tx, b_fall, b_rise, b_sck;

    initial begin
        cycles(3);
        @(negedge clk);
        check("rst_cs_n", {31'd0, spi_cs_n}, 1);
        check("rst_sck", {31'd0, spi_sck}, 0);
        check("rst_mosi", {31'd0, spi_mosi}, 0);
        check("rst_strobe", {31'd0, uart_tx_strobe}, 0);
        check("rst_tx_data", {24'd0, uart_tx_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycles(2);

        // PING
        b_tx = tx_cnt; b_fall = cs_fall;
        exp_q.push_back(8'hA5);
        send(8'h02);
        wait_done("ping_done");
        check("ping_tx_count", tx_cnt - b_tx, 1);
        check("ping_cs_idle", cs_fall - b_fall, 0);

        // unknown opcode then PING
        b_tx = tx_cnt; b_fall = cs_fall;
        exp_q.push_back(8'hEE);
        send(8'h7F);
        wait_done("err_done");
        exp_q.push_back(8'hA5);
        send(8'h02);
        wait_done("err_ping_done");
        check("err_tx_count", tx_cnt - b_tx, 2);
        check("err_cs_idle", cs_fall - b_fall, 0);

        // XFER N=2
        b_tx = tx_cnt; b_fall = cs_fall; b_rise = cs_rise; b_sck = sck_rise;
        miso_q.push_back(8'hEF); miso_q.push_back(8'h40);
        mosi_q.push_back(8'h9F); mosi_q.push_back(8'h00);
        exp_q.push_back(8'hEF);  exp_q.push_back(8'h40);
        send(8'h01); send(8'h00); send(8'h02); send(8'h9F); send(8'h00);
        wait_done("xfer_done");
        check("xfer_sck_rises", sck_rise - b_sck, 16);
        check("xfer_cs_falls", cs_fall - b_fall, 1);
        check("xfer_cs_rises", cs_rise - b_rise, 1);
        check("xfer_cs_after", {31'd0, spi_cs_n}, 1);
        check("xfer_tx_count", tx_cnt - b_tx, 2);
        check("xfer_mosi_left", mosi_q.size(), 0);

        // back-pressure XFER N=3
        b_tx = tx_cnt; b_sck = sck_rise; b_fall = cs_fall;
        uart_tx_ready = 1'b0;
        miso_q.push_back(8'hAA); miso_q.push_back(8'hBB); miso_q.push_back(8'hCC);
        mosi_q.push_back(8'h11); mosi_q.push_back(8'h22); mosi_q.push_back(8'h33);
        exp_q.push_back(8'hAA);  exp_q.push_back(8'hBB);  exp_q.push_back(8'hCC);
        send(8'h01); send(8'h00); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        cycles(44);
        check("bp_stall_rises", sck_rise - b_sck, 8);
        check("bp_stall_tx", tx_cnt - b_tx, 0);
        check("bp_stall_cs", {31'd0, spi_cs_n}, 0);
        uart_tx_ready = 1'b1;
        wait_done("bp_done");
        check("bp_tx_count", tx_cnt - b_tx, 3);
        check("bp_sck_rises", sck_rise - b_sck, 24);
        check("bp_cs_falls", cs_fall - b_fall, 1);

        // overflow while stalled in RESP
        b_tx = tx_cnt;
        uart_tx_ready = 1'b0;
        miso_q.push_back(8'h5A);
        mosi_q.push_back(8'h33);
        send(8'h01); send(8'h00); send(8'h01); send(8'h33);
        cycles(40);
        check("ovf_before", {31'd0, overflow}, 0);
        for (int i = 0; i < 16; i++) send(8'h02);
        for (int i = 0; i < 4; i++)  send(8'h7F);
        @(negedge clk);
        check("ovf_set", {31'd0, overflow}, 1);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        uart_tx_ready = 1'b1;
        wait_done("ovf_done");
        check("ovf_tx_count", tx_cnt - b_tx, 17);

        // zero-length XFER
        b_tx = tx_cnt; b_fall = cs_fall; b_sck = sck_rise;
        send(8'h01); send(8'h00); send(8'h00);
        wait_done("zero_done");
        check("zero_cs_falls", cs_fall - b_fall, 0);
        check("zero_tx_count", tx_cnt - b_tx, 0);
        check("zero_sck_rises", sck_rise - b_sck, 0);
        check("ovf_sticky", {31'd0, overflow}, 1);

        // reset mid-byte
        b_sck = sck_rise;
        miso_q.push_back(8'h3C);
        send(8'h01); send(8'h00); send(8'h01); send(8'hC3);
        wait_rises("rst_mid_reach", b_sck + 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_cs_n", {31'd0, spi_cs_n}, 1);
        check("rst_mid_sck", {31'd0, spi_sck}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_overflow", {31'd0, overflow}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        miso_q.delete();
        b_sck = sck_rise;
        cycles(20);
        check("rst_mid_no_sck", sck_rise - b_sck, 0);
        b_tx = tx_cnt;
        exp_q.push_back(8'hA5);
        send(8'h02);
        wait_done("rst_ping_done");
        check("rst_ping_tx", tx_cnt - b_tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
